rr_stream_arbiter: RTL and testbench

- Round-robin arbiter that merges NUM_IN valid/ready streams into one registered valid/ready output stream.
- Packet-aware: once a source wins a beat with in_last=0, it keeps the output until its in_last beat transfers.
- Sits in front of a downstream pipeline stage and shares that stage fairly among requesters.
- Output stage is a single-entry, full-throughput register with one cycle of latency.

---
 rtl/rr_stream_arbiter.sv | 139 +++++++++++++
 tb/tb_rr_stream_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_arbiter.sv
// Packet-aware round-robin merge of NUM_IN valid/ready streams into one
// registered, full-throughput valid/ready output stage.

// Per-source grant decode: a source is ready only when it is the selected
// source, a grant exists and the output stage can take a beat.
module rr_stream_arbiter_lane #(
   parameter int IDX_W = 2,
   parameter int LANE  = 0
) (
   input  logic [IDX_W-1:0] sel,
   input  logic             grant,
   input  logic             stage_rdy,
   output logic             ready
);
   assign ready = stage_rdy && grant && (sel == IDX_W'(LANE));
endmodule

module rr_stream_arbiter #(
   parameter  int NUM_IN     = 4,
   parameter  int DATA_WIDTH = 32,
   localparam int IDX_W      = $clog2(NUM_IN)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]            in_valid,
   input  logic [NUM_IN-1:0]            in_last,
   output logic [NUM_IN-1:0]            in_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_valid,
   output logic                         out_last,
   output logic [IDX_W-1:0]             out_src,
   input  logic                         out_ready
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
      logic [IDX_W-1:0]      src;
   } beat_t;

   state_t                             state;
   logic [IDX_W-1:0]                   ptr;
   logic [IDX_W-1:0]                   lock_idx;
   logic [IDX_W-1:0]                   scan_idx;
   logic                               scan_hit;
   logic [IDX_W-1:0]                   sel;
   logic [IDX_W-1:0]                   ptr_nxt;
   logic                               grant;
   logic                               stage_rdy;
   logic                               xfer;
   logic [NUM_IN-1:0][DATA_WIDTH-1:0]  lane_data;
   beat_t                              in_beat;
   beat_t                              out_beat;
   logic                               out_vld_q;

   // Index base+k folded back into 0..NUM_IN-1; k never exceeds NUM_IN-1,
   // so one subtraction suffices and non-power-of-two NUM_IN works.
   function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int k);
      int sum;
      sum = int'(base) + k;
      if (sum >= NUM_IN) sum = sum - NUM_IN;
      return IDX_W'(sum);
   endfunction

   assign lane_data = in_data;

   // The register can load whenever it is empty or being drained this cycle.
   assign stage_rdy = !out_vld_q || out_ready;

   // Rotating priority scan: first valid source at or after ptr. Walking k
   // downwards lets the closest candidate overwrite farther ones.
   always_comb begin
      scan_hit = 1'b0;
      scan_idx = '0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         if (in_valid[rot_idx(ptr, k)]) begin
            scan_hit = 1'b1;
            scan_idx = rot_idx(ptr, k);
         end
      end
   end

   // While locked the owner keeps the grant even if it drops valid, so a
   // stalled packet is never interleaved with another source.
   assign sel     = (state == LOCKED) ? lock_idx : scan_idx;
   assign grant   = (state == LOCKED) || scan_hit;
   assign xfer    = grant && stage_rdy && in_valid[sel];
   assign ptr_nxt = (sel == IDX_W'(NUM_IN - 1)) ? '0 : sel + 1'b1;

   assign in_beat = '{data: lane_data[sel], last: in_last[sel], src: sel};

   for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
      rr_stream_arbiter_lane #(
         .IDX_W (IDX_W),
         .LANE  (i)
      ) u_lane (
         .sel       (sel),
         .grant     (grant),
         .stage_rdy (stage_rdy),
         .ready     (in_ready[i])
      );
   end

   // Lock FSM plus output register; ptr advances only at packet end so
   // fairness is per packet, not per beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         lock_idx  <= '0;
         out_vld_q <= 1'b0;
         out_beat  <= '0;
      end else if (stage_rdy) begin
         out_vld_q <= xfer;
         if (xfer) begin
            out_beat <= in_beat;
            if (in_beat.last) begin
               state <= IDLE;
               ptr   <= ptr_nxt;
            end else begin
               state    <= LOCKED;
               lock_idx <= sel;
            end
         end
      end
   end

   assign out_valid = out_vld_q;
   assign out_data  = out_beat.data;
   assign out_last  = out_beat.last;
   assign out_src   = out_beat.src;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Randomized bench for rr_stream_arbiter: per-source packet queues feed the
// DUT, a packet-level round-robin model predicts grants and output beats.
module tb_rr_stream_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;

   typedef struct {
      int            src;
      logic [DW-1:0] data;
      logic          last;
      int            cyc;
   } obs_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N*DW-1:0] in_data = '0;
   logic [N-1:0]    in_valid = '0;
   logic [N-1:0]    in_last = '0;
   logic [N-1:0]    in_ready;
   logic [DW-1:0]   out_data;
   logic            out_valid;
   logic            out_last;
   logic [1:0]      out_src;
   logic            out_ready = 1'b0;

   // stimulus: pending beats per source, {last, data}
   logic [DW:0]     q [N][$];
   logic [N-1:0]    vmask = '1;
   int              vld_pct = 100;
   int              rdy_pct = 100;
   int              cyc = 0;
   obs_t            lg [$];

   // reference model: packet-level round robin
   int              m_ptr, m_owner, m_os;
   bit              m_lock, m_ov;
   logic [DW-1:0]   m_od;
   logic            m_ol;

   int              n_chk = 0;
   int              n_fail = 0;

   rr_stream_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < N; i++)
         if (q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_clear();
      m_ptr = 0; m_owner = 0; m_os = 0;
      m_lock = 1'b0; m_ov = 1'b0; m_od = '0; m_ol = 1'b0;
   endtask

   // One clock: check outputs, drive inputs, predict grant, advance model.
   task automatic step();
      logic [N-1:0] exp_rdy;
      logic [DW:0]  b;
      obs_t         o;
      int           win;
      bit           srdy;
      @(negedge clk);
      cyc++;
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
         chk("out_data", out_data, m_od);
         chk("out_last", out_last, m_ol);
         chk("out_src", out_src, m_os);
      end
      for (int i = 0; i < N; i++) begin
         if (q[i].size() != 0) begin
            b = q[i][0];
            in_valid[i] = vmask[i] && ($urandom_range(99) < vld_pct);
            in_data[i*DW +: DW] = b[DW-1:0];
            in_last[i] = b[DW];
         end else begin
            in_valid[i] = 1'b0;
            in_data[i*DW +: DW] = $urandom;
            in_last[i] = 1'($urandom_range(1));
         end
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      if (out_valid && out_ready) begin
         o.src = int'(out_src); o.data = out_data; o.last = out_last; o.cyc = cyc;
         lg.push_back(o);
      end
      #1;
      srdy = !m_ov || out_ready;
      win = -1;
      if (m_lock) win = m_owner;
      else
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (win < 0 && in_valid[j]) win = j;
         end
      exp_rdy = '0;
      if (win >= 0 && srdy) exp_rdy[win] = 1'b1;
      chk("in_ready", in_ready, exp_rdy);
      if (srdy) begin
         if (win >= 0 && in_valid[win]) begin
            b = q[win].pop_front();
            m_ov = 1'b1; m_od = b[DW-1:0]; m_ol = b[DW]; m_os = win;
            if (b[DW]) begin
               m_lock = 1'b0;
               m_ptr = (win + 1) % N;
            end else begin
               m_lock = 1'b1;
               m_owner = win;
            end
         end else begin
            m_ov = 1'b0;
         end
      end
   endtask

   task automatic drain(input int maxc);
      int n;
      n = 0;
      while (!(all_empty() && !m_ov) && n < maxc) begin
         step();
         n++;
      end
      chk("drain_timeout", (n >= maxc), 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_src", out_src, '0);
      for (int i = 0; i < N; i++) q[i].delete();
      model_clear();
      lg.delete();
      vmask = '1; vld_pct = 100; rdy_pct = 100;
   endtask

   task automatic chk_beat(input string tag, input int idx, input int src, input logic [DW-1:0] data);
      if (idx >= lg.size()) chk({tag, "_missing"}, lg.size(), idx + 1);
      else begin
         chk({tag, "_src"}, lg[idx].src, src);
         chk({tag, "_data"}, lg[idx].data, data);
      end
   endtask

   task automatic chk_contig(input string tag, input int from, input int to);
      for (int k = from + 1; k <= to && k < lg.size(); k++)
         chk(tag, lg[k].cyc, lg[k-1].cyc + 1);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      logic [DW-1:0] d;
      model_clear();
      repeat (2) @(negedge clk);
      do_reset();

      // single source, single beat
      q[2].push_back({1'b1, 32'hA5A5A5A5});
      c0 = cyc;
      drain(50);
      chk_beat("single", 0, 2, 32'hA5A5A5A5);
      if (lg.size() > 0) begin
         chk("single_last", lg[0].last, 1'b1);
         chk("single_latency", lg[0].cyc, c0 + 2);
      end
      lg.delete();
      q[0].push_back({1'b1, 32'h0});
      q[3].push_back({1'b1, 32'h3});
      drain(50);
      chk_beat("ptr_after_single_a", 0, 3, 32'h3);
      chk_beat("ptr_after_single_b", 1, 0, 32'h0);

      // round robin over single-beat packets, no bubbles
      do_reset();
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < N; i++) q[i].push_back({1'b1, DW'(32'h10 + i)});
      drain(100);
      for (int k = 0; k < 2 * N; k++) chk_beat("rr", k, k % N, DW'(32'h10 + k % N));
      chk_contig("rr_no_idle", 0, 2 * N - 1);

      // packet lock: src1 3-beat packet with src0/src2 competing
      do_reset();
      q[0].push_back({1'b1, 32'h0A});
      drain(50);
      lg.delete();
      q[1].push_back({1'b0, 32'h11});
      q[1].push_back({1'b0, 32'h12});
      q[1].push_back({1'b1, 32'h13});
      q[0].push_back({1'b1, 32'h20});
      q[2].push_back({1'b1, 32'h22});
      drain(100);
      chk_beat("lock0", 0, 1, 32'h11);
      chk_beat("lock1", 1, 1, 32'h12);
      chk_beat("lock2", 2, 1, 32'h13);
      chk_beat("lock_next", 3, 2, 32'h22);
      chk_beat("lock_after", 4, 0, 32'h20);
      chk_contig("lock_contig", 0, 2);

      // backpressure holds the registered beat
      do_reset();
      q[0].push_back({1'b1, 32'hDEADBEEF});
      q[1].push_back({1'b1, 32'h00000001});
      rdy_pct = 0;
      step();
      for (int k = 0; k < 3; k++) begin
         step();
         chk("bp_valid", out_valid, 1'b1);
         chk("bp_data", out_data, 32'hDEADBEEF);
         chk("bp_in_ready", in_ready, '0);
      end
      rdy_pct = 100;
      drain(50);
      chk_beat("bp_first", 0, 0, 32'hDEADBEEF);
      chk_beat("bp_second", 1, 1, 32'h00000001);
      chk_contig("bp_follow", 0, 1);

      // locked source stalls; competitor must wait, then ptr wraps to 0
      do_reset();
      q[2].push_back({1'b1, 32'h2});
      drain(50);
      lg.delete();
      q[3].push_back({1'b0, 32'h31});
      q[3].push_back({1'b1, 32'h32});
      q[0].push_back({1'b1, 32'h01});
      step();
      vmask = 4'b0111;
      repeat (2) begin
         step();
         chk("stall_in_ready0", in_ready[0], 1'b0);
         chk("stall_in_ready3", in_ready[3], 1'b1);
      end
      vmask = '1;
      drain(50);
      chk_beat("stall0", 0, 3, 32'h31);
      chk_beat("stall1", 1, 3, 32'h32);
      chk_beat("stall_wrap", 2, 0, 32'h01);

      // reset in the middle of a locked packet
      do_reset();
      q[0].push_back({1'b1, 32'h0B});
      drain(50);
      q[1].push_back({1'b0, 32'hB1});
      q[1].push_back({1'b0, 32'hB2});
      q[1].push_back({1'b1, 32'hB3});
      repeat (2) step();
      do_reset();
      q[0].push_back({1'b1, 32'hA0});
      q[1].push_back({1'b1, 32'hB0});
      drain(50);
      chk_beat("midrst0", 0, 0, 32'hA0);
      chk_beat("midrst1", 1, 1, 32'hB0);

      // randomized traffic
      do_reset();
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < N; i++) begin
            int npk;
            npk = $urandom_range(3);
            for (int p = 0; p < npk; p++) begin
               int len;
               len = $urandom_range(1, 4);
               for (int b = 0; b < len; b++) begin
                  d = $urandom;
                  q[i].push_back({(b == len - 1), d});
               end
            end
         end
         vld_pct = $urandom_range(30, 100);
         rdy_pct = $urandom_range(30, 100);
         drain(3000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
